// File: rtl/piezo_pkg.sv
// Shared types and the fixed note table for the piezo tune sequencer.
package piezo_pkg;

   // One tune entry: half-period in clocks and duration in 1/100 s.
   typedef struct packed {
      logic [14:0] per;
      logic [7:0]  dur;
   } note_t;

   localparam int TUNE_LEN = 6;

   // G6, C7, E7, G7, E7, G7
   localparam note_t TUNE [TUNE_LEN] = '{
      '{per: 15'd15944, dur: 8'd10},
      '{per: 15'd11945, dur: 8'd10},
      '{per: 15'd9480,  dur: 8'd10},
      '{per: 15'd7972,  dur: 8'd15},
      '{per: 15'd9480,  dur: 8'd5},
      '{per: 15'd7972,  dur: 8'd30}
   };

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } seq_state_t;

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: a half-period counter plus a toggle flop.
// Both outputs are forced low whenever the tone is not running.
module piezo_tone_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [14:0] per,
   input  logic        run,
   input  logic        restart,
   output logic        piezo,
   output logic        piezo_n
);

   logic [14:0] freq_cnt_q, freq_cnt_d;
   logic        tone_q, tone_d;

   // Next counter value and tone level; restart zeroes the count but keeps the level.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      freq_cnt_d = freq_cnt_q;
      tone_d     = tone_q;
      if (!run) begin
         freq_cnt_d = '0;
         tone_d     = 1'b0;
      end else if (restart) begin
         freq_cnt_d = '0;
      end else if (freq_cnt_q == per - 15'd1) begin
         freq_cnt_d = '0;
         tone_d     = ~tone_q;
      end else begin
         freq_cnt_d = freq_cnt_q + 15'd1;
      end
   end

   // Counter and tone registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
      if (!rst_n) begin
         freq_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else begin
         freq_cnt_q <= freq_cnt_d;
         tone_q     <= tone_d;
      end
   end

   assign piezo   = run &  tone_q;
   assign piezo_n = run & ~tone_q;

endmodule

// File: rtl/piezo_tune_seq.sv
// Tune sequencer: walks the note table, hands each duration to the external
// duration counter and drives the differential piezo square wave.
// Optional macro PIEZO_GAP_EN inserts a silent gap of GAP_DUR between notes.
module piezo_tune_seq
   import piezo_pkg::*;
#(
   parameter int NUM_NOTES = 6
`ifdef PIEZO_GAP_EN
   ,
   parameter int GAP_DUR   = 2
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       note_over,
   output logic [7:0] note_dur,
   output logic       dur_clr,
   output logic       piezo,
   output logic       piezo_n,
   output logic       busy,
   output logic       done
);

   localparam int                IDX_W    = $clog2(NUM_NOTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

   seq_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   note_t            cur_note;

   assign cur_note = TUNE[idx_q];

   // Next state, note index and the same-cycle dur_clr/done strobes; reset masks the strobes.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dur_clr = 1'b0;
      done    = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = PLAY;
                  idx_d   = '0;
                  dur_clr = 1'b1;
               end
            end
            PLAY: begin
               if (note_over) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = IDLE;
                     idx_d   = '0;
                     done    = 1'b1;
                  end else begin
                     dur_clr = 1'b1;
`ifdef PIEZO_GAP_EN
                     state_d = GAP;
`else
                     idx_d   = idx_q + IDX_W'(1);
`endif
                  end
               end
            end
`ifdef PIEZO_GAP_EN
            GAP: begin
               if (note_over) begin
                  state_d = PLAY;
                  idx_d   = idx_q + IDX_W'(1);
                  dur_clr = 1'b1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // State and note index registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Duration presented to the counter for the current note or gap.
   always_comb begin
      note_dur = 8'd0;
      case (state_q)
         PLAY:    note_dur = cur_note.dur;
`ifdef PIEZO_GAP_EN
         GAP:     note_dur = 8'(GAP_DUR);
`endif
         default: note_dur = 8'd0;
      endcase
   end

   assign busy = (state_q != IDLE);

   piezo_tone_gen u_tone (
      .clk     (clk),
      .rst_n   (rst_n),
      .per     (cur_note.per),
      .run     (state_q == PLAY),
      .restart (dur_clr),
      .piezo   (piezo),
      .piezo_n (piezo_n)
   );

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Bench for piezo_tune_seq: pairs the DUT with a duration-counter model and
// checks every output each cycle against a note-level model of the tune.
module tb_piezo_tune_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       note_over;
   logic [7:0] note_dur;
   logic       dur_clr, piezo, piezo_n, busy, done;

   always #10 clk = ~clk;

   piezo_tune_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .note_over (note_over),
      .note_dur  (note_dur),
      .dur_clr   (dur_clr),
      .piezo     (piezo),
      .piezo_n   (piezo_n),
      .busy      (busy),
      .done      (done)
   );

`ifdef PIEZO_GAP_EN
   localparam bit GAP_EN   = 1'b1;
   localparam int CLR_RUN  = 11;
   int            exp_seq [$] = '{10, 2, 10, 2, 10, 2, 15, 2, 5, 2, 30};
`else
   localparam bit GAP_EN   = 1'b0;
   localparam int CLR_RUN  = 6;
   int            exp_seq [$] = '{10, 10, 10, 15, 5, 30};
`endif
   localparam int NUM      = 6;
   localparam int GAP_LEN  = 2;

   int PER [NUM] = '{15944, 11945, 9480, 7972, 9480, 7972};
   int DUR [NUM] = '{10, 10, 10, 15, 5, 30};

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Duration counter environment: counts enable ticks since the last clear.
   int         en_div = 2000;
   int         pre;
   logic [7:0] dcnt;
   always @(posedge clk) begin
      if (!rst_n) begin
         pre  <= 0;
         dcnt <= 8'd0;
      end else begin
         pre <= (pre >= en_div - 1) ? 0 : pre + 1;
         if (dur_clr)
            dcnt <= 8'd0;
         else if (pre >= en_div - 1 && dcnt != note_dur)
            dcnt <= dcnt + 8'd1;
      end
   end
   assign note_over = (dcnt == note_dur);

   // Note-level model: which note (or gap) is sounding and how long it has sounded.
   bit m_valid = 1'b0;
   bit m_busy, m_gap, m_lvl;
   int m_note, m_t;
   int clr_cnt = 0, done_cnt = 0;
   bit prev_clr = 1'b0, rec_en = 1'b0;
   int dur_seq [$];

   function automatic bit level_now();
      return m_lvl ^ bit'((m_t / PER[m_note]) % 2);
   endfunction

   always @(negedge clk) begin
      bit       sounding, lvl, last, e_clr, e_done;
      int       e_dur;
      sounding = m_busy && !m_gap;
      lvl      = sounding ? level_now() : 1'b0;
      last     = m_busy && !m_gap && (m_note == NUM - 1);
      if (m_valid) begin
         e_dur  = !m_busy ? 0 : (m_gap ? GAP_LEN : DUR[m_note]);
         e_clr  = rst_n && ((!m_busy && start) || (m_busy && note_over && !last));
         e_done = rst_n && last && note_over;
         check("busy",     32'(busy),     32'(m_busy));
         check("note_dur", 32'(note_dur), 32'(e_dur));
         check("dur_clr",  32'(dur_clr),  32'(e_clr));
         check("done",     32'(done),     32'(e_done));
         check("piezo",    32'(piezo),    32'(sounding && lvl));
         check("piezo_n",  32'(piezo_n),  32'(sounding && !lvl));
         if (rec_en && prev_clr) dur_seq.push_back(int'(note_dur));
         prev_clr = (dur_clr === 1'b1);
         if (dur_clr === 1'b1) clr_cnt++;
         if (done === 1'b1) done_cnt++;
      end
      // advance to the state seen after the coming clock edge
      if (!rst_n) begin
         m_busy = 1'b0;
         m_gap  = 1'b0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1'b1; m_gap = 1'b0; m_note = 0; m_t = 0; m_lvl = 1'b0;
         end
      end else if (note_over) begin
         if (last) begin
            m_busy = 1'b0;
         end else if (GAP_EN && !m_gap) begin
            m_gap = 1'b1; m_t = 0;
         end else begin
            m_lvl  = m_gap ? 1'b0 : lvl;
            m_note = m_note + 1;
            m_gap  = 1'b0;
            m_t    = 0;
         end
      end else begin
         m_t++;
      end
      if (!rst_n) m_valid = 1'b1;
   end

   int run_base = 0;

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_clr(input int n, input int budget);
      int k = 0;
      while (clr_cnt - run_base < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check("wait_clr_in_time", 32'(clr_cnt - run_base >= n), 32'd1);
   endtask

   // Stops in the cycle whose note_over ends the last note (done cycle).
   task automatic wait_done_cycle(input int budget);
      bit found = 1'b0;
      for (int k = 0; k < budget && !found; k++) begin
         @(posedge clk); #1;
         if (note_over === 1'b1 && busy === 1'b1 && clr_cnt - run_base == CLR_RUN) found = 1'b1;
      end
      check("wait_done_in_time", 32'(found), 32'd1);
   endtask

   initial begin
      int done_base;
      // reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_piezo",    32'(piezo),    32'd0);
      check("rst_piezo_n",  32'(piezo_n),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_dur_clr",  32'(dur_clr),  32'd0);
      check("rst_note_dur", 32'(note_dur), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;

      // run 1: slow enable so the first tone toggles inside note 0
      run_base  = clr_cnt;
      done_base = done_cnt;
      rec_en    = 1'b1;
      start     = 1'b1;
      #1;
      check("start_dur_clr", 32'(dur_clr), 32'd1);
      check("start_busy_lo", 32'(busy),    32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("play_busy",     32'(busy),     32'd1);
      check("play_note_dur", 32'(note_dur), 32'd10);
      check("play_piezo",    32'(piezo),    32'd0);
      check("play_piezo_n",  32'(piezo_n),  32'd1);
      repeat (15943) @(posedge clk);
      #1;
      check("pz_before_toggle", 32'(piezo), 32'd0);
      @(posedge clk); #1;
      check("pz_toggled",   32'(piezo),   32'd1);
      check("pzn_toggled",  32'(piezo_n), 32'd0);

      // let note 1 sound past its first toggle, then speed up the enable
      wait_clr(GAP_EN ? 3 : 2, 40000);
      repeat (12500) @(posedge clk);
      #1;
      en_div = 100;

      // start during note 2 is ignored
      wait_clr(GAP_EN ? 5 : 3, 20000);
      pulse_start();

      // start during the done cycle is ignored
      wait_done_cycle(20000);
      start = 1'b1;
      #1;
      check("done_pulse", 32'(done), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      check("end_busy",    32'(busy),    32'd0);
      check("end_piezo",   32'(piezo),   32'd0);
      check("end_piezo_n", 32'(piezo_n), 32'd0);
      rec_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_done", 32'(busy), 32'd0);
      check("run1_clr_pulses", 32'(clr_cnt - run_base), 32'(CLR_RUN));
      check("run1_done_count", 32'(done_cnt - done_base), 32'd1);
      check("run1_seq_len", 32'(dur_seq.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < dur_seq.size(); i++)
         check($sformatf("run1_seq[%0d]", i), 32'(dur_seq[i]), 32'(exp_seq[i]));

      // run 2: reset in the middle of note 3
      run_base = clr_cnt;
      pulse_start();
      wait_clr(GAP_EN ? 7 : 4, 20000);
      repeat (300) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_busy",     32'(busy),     32'd0);
      check("mid_rst_piezo",    32'(piezo),    32'd0);
      check("mid_rst_piezo_n",  32'(piezo_n),  32'd0);
      check("mid_rst_note_dur", 32'(note_dur), 32'd0);
      check("mid_rst_dur_clr",  32'(dur_clr),  32'd0);
      check("mid_rst_done",     32'(done),     32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // run 3: replays from G6 and completes
      run_base  = clr_cnt;
      done_base = done_cnt;
      pulse_start();
      check("replay_note_dur", 32'(note_dur), 32'd10);
      check("replay_piezo_n",  32'(piezo_n),  32'd1);
      wait_done_cycle(20000);
      repeat (3) @(posedge clk);
      #1;
      check("run3_idle",       32'(busy), 32'd0);
      check("run3_clr_pulses", 32'(clr_cnt - run_base), 32'(CLR_RUN));
      check("run3_done_count", 32'(done_cnt - done_base), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
